// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM controller encodings: init/work state codes and status widths.
// Also used by sdram_cmd to decode the command/address mux from the state outputs.
package sdram_ctrl_pkg;

    localparam int ST_W  = 4;
    localparam int REF_W = 4;
    localparam int AR_W  = 4;

    typedef enum logic [ST_W-1:0] {
        I_NOP  = 4'd0,
        I_PRE  = 4'd1,
        I_TRP  = 4'd2,
        I_AR   = 4'd3,
        I_TRF  = 4'd4,
        I_MRS  = 4'd5,
        I_TRSC = 4'd6,
        I_DONE = 4'd7
    } init_state_e;

    typedef enum logic [ST_W-1:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_WRITE  = 4'd3,
        W_WD     = 4'd4,
        W_TWR    = 4'd5,
        W_READ   = 4'd6,
        W_CL     = 4'd7,
        W_RD     = 4'd8,
        W_PRE    = 4'd9,
        W_TRP    = 4'd10,
        W_AR     = 4'd11,
        W_TRFC   = 4'd12
    } work_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer with a saturating postponed-refresh debt counter.
// Latency: debt updates one cycle after timer wrap / ref_take; no backpressure (ref_take consumes one unit).
module sdram_ref_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int T_REFI  = 782,
    parameter int REF_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_take,
    output logic [REF_W-1:0] ref_pend
);

    localparam int TW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    logic [TW-1:0]    refi_cnt_q, refi_cnt_d;
    logic [REF_W-1:0] ref_pend_q, ref_pend_d;
    logic             refi_wrap;

    always_comb begin
        refi_wrap  = (refi_cnt_q == TW'(T_REFI - 1));
        refi_cnt_d = refi_wrap ? '0 : refi_cnt_q + TW'(1);
        ref_pend_d = ref_pend_q;
        // A wrap coinciding with a take cancels out.
        if (refi_wrap && !ref_take) begin
            if (ref_pend_q != REF_W'(REF_MAX)) begin
                ref_pend_d = ref_pend_q + REF_W'(1);
            end
        end else if (!refi_wrap && ref_take && (ref_pend_q != '0)) begin
            ref_pend_d = ref_pend_q - REF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refi_cnt_q <= '0;
            ref_pend_q <= '0;
        end else begin
            refi_cnt_q <= refi_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    assign ref_pend = ref_pend_q;

endmodule

// File: rtl/sdram_ctrl_gen2.sv
// SDRAM sequencer: power-up init, then round-robin write/read access with postponable auto-refresh.
// Latency: grant one cycle after request seen in idle; requests are held by the master until acked, never dropped.
module sdram_ctrl_gen2
    import sdram_ctrl_pkg::*;
#(
    parameter int T_PWR   = 20000,
    parameter int T_REFI  = 782,
    parameter int REF_MAX = 4,
    parameter int INIT_AR = 8,
    parameter int TRP     = 4,
    parameter int TRC     = 6,
    parameter int TMRD    = 6,
    parameter int TRCD    = 2,
    parameter int TCL     = 3,
    parameter int TWR     = 2,
    parameter int BL_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [BL_W-1:0]  wr_burst,
    input  logic [BL_W-1:0]  rd_burst,
    output logic             wr_ack,
    output logic             rd_ack,
    output logic             init_done,
    output logic [ST_W-1:0]  init_state,
    output logic [ST_W-1:0]  work_state,
    output logic [BL_W:0]    cnt_clk,
    output logic             rd_wr,
    output logic [REF_W-1:0] ref_pend
);

    localparam int CW = BL_W + 1;
    localparam int PW = $clog2(T_PWR);

    init_state_e      init_state_q, init_state_d;
    work_state_e      work_state_q, work_state_d;
    logic [CW-1:0]    cnt_clk_q, cnt_clk_d;
    logic [PW-1:0]    pwr_cnt_q, pwr_cnt_d;
    logic [AR_W-1:0]  ar_cnt_q, ar_cnt_d;
    logic [BL_W-1:0]  burst_q, burst_d;
    logic             rd_wr_q, rd_wr_d;
    logic             last_rd_q, last_rd_d;
    logic             ref_take;
    logic [REF_W-1:0] ref_pend_w;

    sdram_ref_timer #(
        .T_REFI  (T_REFI),
        .REF_MAX (REF_MAX)
    ) u_ref_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ref_take (ref_take),
        .ref_pend (ref_pend_w)
    );

    assign init_done = (init_state_q == I_DONE);

    always_comb begin
        init_state_d = init_state_q;
        pwr_cnt_d    = '0;
        ar_cnt_d     = ar_cnt_q;
        case (init_state_q)
            I_NOP: begin
                pwr_cnt_d = pwr_cnt_q + PW'(1);
                if (pwr_cnt_q == PW'(T_PWR - 1)) begin
                    pwr_cnt_d    = '0;
                    init_state_d = I_PRE;
                end
            end
            I_PRE: begin
                if (TRP > 1) init_state_d = I_TRP;
                else         init_state_d = I_AR;
            end
            I_TRP: if (cnt_clk_q == CW'(TRP - 2)) init_state_d = I_AR;
            I_AR: begin
                ar_cnt_d = ar_cnt_q + AR_W'(1);
                if (TRC > 1)                               init_state_d = I_TRF;
                else if (ar_cnt_q == AR_W'(INIT_AR - 1))   init_state_d = I_MRS;
            end
            I_TRF: begin
                // ar_cnt already counts the refresh that led into this wait.
                if (cnt_clk_q == CW'(TRC - 2)) begin
                    if (ar_cnt_q == AR_W'(INIT_AR)) init_state_d = I_MRS;
                    else                            init_state_d = I_AR;
                end
            end
            I_MRS: begin
                if (TMRD > 1) init_state_d = I_TRSC;
                else          init_state_d = I_DONE;
            end
            I_TRSC: if (cnt_clk_q == CW'(TMRD - 2)) init_state_d = I_DONE;
            default: ;
        endcase
    end

    always_comb begin
        work_state_d = work_state_q;
        burst_d      = burst_q;
        rd_wr_d      = rd_wr_q;
        last_rd_d    = last_rd_q;
        ref_take     = 1'b0;
        case (work_state_q)
            W_IDLE: begin
                if (init_done) begin
                    if (ref_pend_w == REF_W'(REF_MAX)) begin
                        work_state_d = W_AR;
                        ref_take     = 1'b1;
                    end else if (wr_req && (!rd_req || last_rd_q)) begin
                        work_state_d = W_ACTIVE;
                        rd_wr_d      = 1'b0;
                        last_rd_d    = 1'b0;
                        burst_d      = (wr_burst == '0) ? BL_W'(1) : wr_burst;
                    end else if (rd_req) begin
                        work_state_d = W_ACTIVE;
                        rd_wr_d      = 1'b1;
                        last_rd_d    = 1'b1;
                        burst_d      = (rd_burst == '0) ? BL_W'(1) : rd_burst;
                    end else if (ref_pend_w != '0) begin
                        work_state_d = W_AR;
                        ref_take     = 1'b1;
                    end
                end
            end
            W_ACTIVE: begin
                if (TRCD > 1)     work_state_d = W_TRCD;
                else if (rd_wr_q) work_state_d = W_READ;
                else              work_state_d = W_WRITE;
            end
            W_TRCD: begin
                if (cnt_clk_q == CW'(TRCD - 2)) begin
                    if (rd_wr_q) work_state_d = W_READ;
                    else         work_state_d = W_WRITE;
                end
            end
            W_WRITE: begin
                if (burst_q == BL_W'(1)) work_state_d = W_TWR;
                else                     work_state_d = W_WD;
            end
            W_WD:   if (cnt_clk_q == {1'b0, burst_q} - CW'(2)) work_state_d = W_TWR;
            W_TWR:  if (cnt_clk_q == CW'(TWR - 1))             work_state_d = W_PRE;
            W_READ: work_state_d = W_CL;
            W_CL:   if (cnt_clk_q == CW'(TCL - 2))             work_state_d = W_RD;
            W_RD:   if (cnt_clk_q == {1'b0, burst_q} - CW'(1)) work_state_d = W_PRE;
            W_PRE: begin
                if (TRP > 1) begin
                    work_state_d = W_TRP;
                end else begin
                    work_state_d = W_IDLE;
                    rd_wr_d      = 1'b1;
                end
            end
            W_TRP: begin
                if (cnt_clk_q == CW'(TRP - 2)) begin
                    work_state_d = W_IDLE;
                    rd_wr_d      = 1'b1;
                end
            end
            W_AR: begin
                if (TRC > 1) work_state_d = W_TRFC;
                else         work_state_d = W_IDLE;
            end
            W_TRFC: if (cnt_clk_q == CW'(TRC - 2)) work_state_d = W_IDLE;
            default: work_state_d = W_IDLE;
        endcase
    end

    // Saturates in the open-ended states (I_DONE/W_IDLE); I_NOP uses pwr_cnt instead.
    always_comb begin
        cnt_clk_d = cnt_clk_q;
        if ((init_state_q == I_NOP) || (init_state_d != init_state_q) ||
            (work_state_d != work_state_q)) begin
            cnt_clk_d = '0;
        end else if (cnt_clk_q != '1) begin
            cnt_clk_d = cnt_clk_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_state_q <= I_NOP;
            work_state_q <= W_IDLE;
            cnt_clk_q    <= '0;
            pwr_cnt_q    <= '0;
            ar_cnt_q     <= '0;
            burst_q      <= '0;
            rd_wr_q      <= 1'b1;
            last_rd_q    <= 1'b1;
        end else begin
            init_state_q <= init_state_d;
            work_state_q <= work_state_d;
            cnt_clk_q    <= cnt_clk_d;
            pwr_cnt_q    <= pwr_cnt_d;
            ar_cnt_q     <= ar_cnt_d;
            burst_q      <= burst_d;
            rd_wr_q      <= rd_wr_d;
            last_rd_q    <= last_rd_d;
        end
    end

    assign init_state = init_state_q;
    assign work_state = work_state_q;
    assign cnt_clk    = cnt_clk_q;
    assign rd_wr      = rd_wr_q;
    assign ref_pend   = ref_pend_w;
    assign wr_ack     = (work_state_q == W_WRITE) || (work_state_q == W_WD);
    assign rd_ack     = (work_state_q == W_RD);

endmodule

// File: tb/tb_sdram_ctrl_gen2.sv
// Directed bench for sdram_ctrl_gen2 with shortened init/refresh timing.
// Expected cycle numbers are hand-derived from the state durations.
module tb_sdram_ctrl_gen2;
    import sdram_ctrl_pkg::*;

    localparam int BL_W = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_req = 1'b0;
    logic            rd_req = 1'b0;
    logic [BL_W-1:0] wr_burst = '0;
    logic [BL_W-1:0] rd_burst = '0;
    logic            wr_ack, rd_ack, init_done, rd_wr;
    logic [3:0]      init_state, work_state, ref_pend;
    logic [BL_W:0]   cnt_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    sdram_ctrl_gen2 #(
        .T_PWR   (10),
        .T_REFI  (200),
        .REF_MAX (2),
        .INIT_AR (2),
        .TRP     (4),
        .TRC     (6),
        .TMRD    (6),
        .TRCD    (2),
        .TCL     (3),
        .TWR     (2),
        .BL_W    (BL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .wr_burst   (wr_burst),
        .rd_burst   (rd_burst),
        .wr_ack     (wr_ack),
        .rd_ack     (rd_ack),
        .init_done  (init_done),
        .init_state (init_state),
        .work_state (work_state),
        .cnt_clk    (cnt_clk),
        .rd_wr      (rd_wr),
        .ref_pend   (ref_pend)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string p);
        check_eq({p, "_init_state"}, init_state, I_NOP);
        check_eq({p, "_work_state"}, work_state, W_IDLE);
        check_eq({p, "_cnt_clk"}, cnt_clk, 0);
        check_eq({p, "_rd_wr"}, rd_wr, 1);
        check_eq({p, "_ref_pend"}, ref_pend, 0);
        check_eq({p, "_acks"}, {wr_ack, rd_ack}, 0);
        check_eq({p, "_init_done"}, init_done, 0);
    endtask

    // Entered with cyc==0 just after reset release.
    task automatic run_init(input string p);
        int ar_seen = 0;
        for (int i = 1; i <= 32; i++) begin
            if (init_state == I_AR) ar_seen++;
            step();
            if (cyc == 10) check_eq({p, "_pre_at_10"}, init_state, I_PRE);
            if (cyc == 13) check_eq({p, "_trp_cnt"}, cnt_clk, 2);
            if (cyc == 31) check_eq({p, "_done_at_31"}, init_done, 0);
        end
        check_eq({p, "_done_at_32"}, init_done, 1);
        check_eq({p, "_state_done"}, init_state, I_DONE);
        check_eq({p, "_ar_visits"}, ar_seen, 2);
    endtask

    initial begin
        int t0, first_ack, ack_cnt, last_ack, g, wr_g, rd_g, ar_n, bad_ar, max_pend;
        int prev_pend, diff;
        logic [3:0] prev_ws;
        logic [3:0] grants [4];
        logic ok;

        step();
        step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc = 0;
        run_init("init");

        // Write, B=4
        wr_burst = 10'd4;
        wr_req = 1'b1;
        t0 = cyc; first_ack = -1; ack_cnt = 0; last_ack = -1;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (cyc == t0 + 1) check_eq("wr_active", work_state, W_ACTIVE);
            if (cyc == t0 + 1) check_eq("wr_rdwr_low", rd_wr, 0);
            if (cyc == t0 + 3) check_eq("wr_write", work_state, W_WRITE);
            if (cyc == t0 + 12) check_eq("wr_trp_tail", work_state, W_TRP);
            if (wr_ack) begin
                ack_cnt++;
                last_ack = cyc - t0;
                if (first_ack < 0) first_ack = cyc - t0;
                wr_req = 1'b0;
            end
        end
        check_eq("wr_first_ack", first_ack, 3);
        check_eq("wr_last_ack", last_ack, 6);
        check_eq("wr_ack_cnt", ack_cnt, 4);
        check_eq("wr_idle", work_state, W_IDLE);
        check_eq("wr_rdwr_idle", rd_wr, 1);

        // Read B=1 then B=0 (treated as 1)
        for (int k = 0; k < 2; k++) begin
            rd_burst = (k == 0) ? 10'd1 : 10'd0;
            rd_req = 1'b1;
            t0 = cyc; first_ack = -1; ack_cnt = 0;
            for (int i = 1; i <= 11; i++) begin
                step();
                if (rd_ack) begin
                    ack_cnt++;
                    if (first_ack < 0) first_ack = cyc - t0;
                    rd_req = 1'b0;
                end
            end
            check_eq($sformatf("rd_b%0d_first_ack", k), first_ack, 6);
            check_eq($sformatf("rd_b%0d_ack_cnt", k), ack_cnt, 1);
            check_eq($sformatf("rd_b%0d_idle", k), work_state, W_IDLE);
        end

        // Contention: grants alternate, write first after a read
        wr_burst = 10'd1; rd_burst = 10'd1;
        wr_req = 1'b1; rd_req = 1'b1;
        g = 0;
        for (int i = 0; i < 100 && g < 4; i++) begin
            step();
            if (work_state == W_ACTIVE) begin
                grants[g] = {3'b000, rd_wr};
                g++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check_eq("rr_grants", g, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < g) check_eq($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 1) ? 1 : 0);
        end
        for (int i = 0; i < 20 && work_state != W_IDLE; i++) step();
        check_eq("rr_drain", work_state, W_IDLE);

        // Refresh debt under continuous requests
        wr_burst = 10'd2; rd_burst = 10'd3;
        wr_req = 1'b1; rd_req = 1'b1;
        wr_g = 0; rd_g = 0; ar_n = 0; bad_ar = 0; max_pend = 0;
        prev_pend = ref_pend; prev_ws = work_state;
        while (cyc < 900) begin
            step();
            if (ref_pend > max_pend) max_pend = ref_pend;
            if (work_state == W_AR && prev_ws != W_AR) begin
                ar_n++;
                if (prev_pend != 2) bad_ar++;
            end
            if (work_state == W_ACTIVE) begin
                if (rd_wr) rd_g++;
                else       wr_g++;
            end
            prev_pend = ref_pend;
            prev_ws = work_state;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        diff = (wr_g > rd_g) ? wr_g - rd_g : rd_g - wr_g;
        check_eq("ref_max_pend", max_pend, 2);
        check_eq("ref_ar_count", ar_n, 3);
        check_eq("ref_ar_forced_at_max", bad_ar, 0);
        check_eq("ref_rr_balance", diff <= 1, 1);
        check_eq("ref_both_served", (wr_g > 0) && (rd_g > 0), 1);

        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = (work_state == W_IDLE) && (ref_pend == 0);
        end
        check_eq("ref_drain", ok, 1);

        // Async reset in the middle of a write burst
        wr_burst = 10'd8;
        wr_req = 1'b1;
        for (int i = 0; i < 20 && work_state != W_WD; i++) begin
            step();
            if (wr_ack) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        step();
        step();
        check_eq("pre_rst_wd", work_state, W_WD);
        #2;
        rst_n = 1'b0;
        step();
        check_reset_vals("midrst");
        rst_n = 1'b1;
        cyc = 0;
        run_init("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
